// File: rtl/id_ex_control_stage.sv
// ----------------------------------------------------------------------------
// id_ex_control_stage
//
// Decodes the opcode of the instruction sitting in ID into the main control
// signals, then registers them into the ID/EX pipeline boundary.
//
// The ID/EX register supports:
//   - stall : hold the current EX contents
//   - flush : replace the EX contents with a bubble
//   - bubble insertion when ID does not hold a real instruction
//
// Illegal opcodes are flagged in EX and counted in a saturating counter.
//
// Update priority at each rising edge (highest first):
//   reset > flush > stall > (id_valid == 0) > load decode
//
// All outputs come straight from flops, so there is no combinational path
// from any input to any output.
// ----------------------------------------------------------------------------
module id_ex_control_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [1:0]       ex_aluop,
    output logic [5:0]       ex_funct,
    output logic             ex_regdst,
    output logic             ex_alusrc,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_branch,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    // ------------------------------------------------------------------------
    // Opcode and ALUOp encodings
    // ------------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_UNK   = 2'b11;

    // ------------------------------------------------------------------------
    // Control bundle carried across the ID/EX boundary
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       valid;
        logic [1:0] aluop;
        logic [5:0] funct;
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    // A bubble is the all-zero bundle: aluop=00, funct=0, not valid, not illegal.
    localparam ctrl_t BUBBLE = '0;

    ctrl_t            dec;
    ctrl_t            ex_q;
    logic [5:0]       opcode;
    logic             load_en;
    logic             load_illegal;
    logic             count_sat;
    logic             unused_instr_bits;

    assign opcode = id_instr[31:26];

    // Only the opcode and funct fields matter to this stage; the register
    // and immediate fields are consumed elsewhere.
    assign unused_instr_bits = ^id_instr[25:6];

    // ------------------------------------------------------------------------
    // Main control decode of the instruction in ID
    // ------------------------------------------------------------------------
    always_comb begin
        dec = BUBBLE;
        unique case (opcode)
            OP_RTYPE: begin
                // The all-zero NOP lands here too: it writes $0, which is harmless.
                dec.valid    = 1'b1;
                dec.aluop    = ALU_FUNCT;
                dec.funct    = id_instr[5:0];
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_LW: begin
                dec.valid    = 1'b1;
                dec.aluop    = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            OP_SW: begin
                dec.valid    = 1'b1;
                dec.aluop    = ALU_ADD;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec.valid    = 1'b1;
                dec.aluop    = ALU_SUB;
                dec.branch   = 1'b1;
            end
            default: begin
                // Illegal: flagged but never valid, and every enable stays low
                // so nothing downstream can commit a side effect.
                dec.aluop    = ALU_UNK;
                dec.illegal  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Load qualification: the register takes a fresh decode only when no
    // higher-priority action (reset, flush, stall, bubble) applies.
    // ------------------------------------------------------------------------
    assign load_en      = !reset && !flush && !stall && id_valid;
    assign load_illegal = load_en && dec.illegal;
    assign count_sat    = (illegal_count == {CNT_W{1'b1}});

    // ------------------------------------------------------------------------
    // ID/EX control register with reset/flush/stall/bubble priority
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= BUBBLE;
        end else if (flush) begin
            ex_q <= BUBBLE;
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (!id_valid) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= dec;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating illegal-opcode counter; a held illegal counts only once
    // because a stalled edge never loads.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_count <= '0;
        end else if (load_illegal && !count_sat) begin
            illegal_count <= illegal_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping straight from the register
    // ------------------------------------------------------------------------
    assign ex_valid    = ex_q.valid;
    assign ex_aluop    = ex_q.aluop;
    assign ex_funct    = ex_q.funct;
    assign ex_regdst   = ex_q.regdst;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_memtoreg = ex_q.memtoreg;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_branch   = ex_q.branch;
    assign ex_illegal  = ex_q.illegal;

endmodule
